imm_gen_pipe: RTL

//  Pipelined, parametrised immediate generator. Accepts raw 32-bit RV instructions over a

---
 rtl/imm_gen_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator with a DEPTH-entry output FIFO.
// Each accepted instruction is decoded on entry. Its immediate, format code and
// sideband tag are stored, and the FIFO head drives the outputs directly.
// Optional feature: define IMMGEN_ILLEGAL_EN to add the out_illegal port and a
// per-entry illegal flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ILLEGAL_EN
    ,
    output logic             out_illegal
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    // Sign-extend a 32-bit immediate from bit 31 to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [XLEN-1:0]  imm_mem_r [DEPTH];
    logic [2:0]       fmt_mem_r [DEPTH];
    logic [TAG_W-1:0] tag_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [XLEN-1:0]  imm_dec_s;
    logic [2:0]       fmt_dec_s;
    logic [XLEN-1:0]  imm_s;
    logic [2:0]       fmt_s;
    logic             push_s;
    logic             pop_s;

    // Decode the incoming instruction into format code and extended immediate.
    always_comb begin
        fmt_dec_s = FMT_NONE;
        imm_dec_s = '0;
        case (in_instr[6:0])
            7'b0010011: begin
                if ((in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101)) begin
                    fmt_dec_s = FMT_SHAMT;
                    if (XLEN == 32) begin
                        imm_dec_s = XLEN'({27'd0, in_instr[24:20]});
                    end else begin
                        imm_dec_s = XLEN'({26'd0, in_instr[25:20]});
                    end
                end else begin
                    fmt_dec_s = FMT_I;
                    imm_dec_s = sext32({{20{in_instr[31]}}, in_instr[31:20]});
                end
            end
            7'b0000011, 7'b1100111: begin
                fmt_dec_s = FMT_I;
                imm_dec_s = sext32({{20{in_instr[31]}}, in_instr[31:20]});
            end
            7'b0100011: begin
                fmt_dec_s = FMT_S;
                imm_dec_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            end
            7'b1100011: begin
                fmt_dec_s = FMT_B;
                imm_dec_s = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                    in_instr[30:25], in_instr[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                fmt_dec_s = FMT_U;
                imm_dec_s = sext32({in_instr[31:12], 12'd0});
            end
            7'b1101111: begin
                fmt_dec_s = FMT_J;
                imm_dec_s = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                    in_instr[20], in_instr[30:21], 1'b0});
            end
            default: begin
                fmt_dec_s = FMT_NONE;
                imm_dec_s = '0;
            end
        endcase
    end

`ifdef IMMGEN_ILLEGAL_EN
    logic ill_s;
    logic ill_mem_r [DEPTH];

    // Illegal: not a 32-bit encoding, or an opcode that is neither decoded here nor a
    // known immediate-free opcode (OP, SYSTEM, MISC-MEM).
    always_comb begin
        ill_s = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            ill_s = 1'b1;
        end else if ((fmt_dec_s == FMT_NONE) && (in_instr[6:0] != 7'b0110011) &&
                     (in_instr[6:0] != 7'b1110011) && (in_instr[6:0] != 7'b0001111)) begin
            ill_s = 1'b1;
        end else begin
            ill_s = 1'b0;
        end
    end

    assign fmt_s = ill_s ? FMT_NONE : fmt_dec_s;
    assign imm_s = ill_s ? '0 : imm_dec_s;
    assign out_illegal = ill_mem_r[rd_ptr_r];
`else
    assign fmt_s = fmt_dec_s;
    assign imm_s = imm_dec_s;
`endif

    assign in_ready  = (count_r != CNT_W'(DEPTH));
    assign out_valid = (count_r != '0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    assign out_imm = imm_mem_r[rd_ptr_r];
    assign out_fmt = fmt_mem_r[rd_ptr_r];
    assign out_tag = tag_mem_r[rd_ptr_r];

    // FIFO storage: write decoded entry on push; reset clears every slot so the head reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem_r[i] <= '0;
                fmt_mem_r[i] <= FMT_NONE;
                tag_mem_r[i] <= '0;
`ifdef IMMGEN_ILLEGAL_EN
                ill_mem_r[i] <= 1'b0;
`endif
            end
        end else if (push_s) begin
            imm_mem_r[wr_ptr_r] <= imm_s;
            fmt_mem_r[wr_ptr_r] <= fmt_s;
            tag_mem_r[wr_ptr_r] <= in_tag;
`ifdef IMMGEN_ILLEGAL_EN
            ill_mem_r[wr_ptr_r] <= ill_s;
`endif
        end
    end

    // Read/write pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy count: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
